mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_arb_select.sv | 23 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, one-hot grant values and the default grant timeout live
// here so the arbiter, its selector and any testbench agree on them.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_IF   = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;

   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   // Maps a one-hot winner onto the state that owns the shared port.
   function automatic arb_state_t state_for_grant(input logic [1:0] grant);
      case (grant)
         GRANT_IF: return GNT_IF;
         GRANT_D:  return GNT_D;
         default:  return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Two-input winner selection for the memory arbiter.
// Purely combinational: given the two request lines and which side is
// currently preferred, produce a one-hot winner (or none).
module arb_select
   import mem_arb_pkg::*;
(
   input  logic       req_if,
   input  logic       req_d,
   input  logic       pri_d,
   output logic [1:0] win
);

   // D wins when it is preferred or when IF is not asking; otherwise IF.
   always_comb begin
      win = GRANT_NONE;
      if (req_d && (pri_d || !req_if)) begin
         win = GRANT_D;
      end else if (req_if) begin
         win = GRANT_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory-map port between an instruction-fetch read
// port (IF) and a data read/write port (D).
// Optional feature: define MEM_ARB_RR_EN for round-robin priority; by
// default D always beats IF, except for the single arbitration right after
// D has its grant revoked by timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_if_addr,
   input  logic                  i_if_rd_ready,
   output logic                  o_if_rd_valid,
   output logic [DATA_WIDTH-1:0] o_if_data,
   input  logic [31:0]           i_d_addr,
   input  logic [DATA_WIDTH-1:0] i_d_data,
   input  logic [2:0]            i_d_wr_width,
   input  logic                  i_d_wr_valid,
   output logic                  o_d_wr_ready,
   input  logic                  i_d_rd_ready,
   output logic                  o_d_rd_valid,
   output logic [DATA_WIDTH-1:0] o_d_data,
   output logic [31:0]           o_mm_addr,
   output logic [DATA_WIDTH-1:0] o_mm_data,
   output logic [2:0]            o_mm_wr_width,
   output logic                  o_mm_wr_valid,
   input  logic                  i_mm_wr_ready,
   output logic                  o_mm_rd_ready,
   input  logic                  i_mm_rd_valid,
   input  logic [DATA_WIDTH-1:0] i_mm_data,
   output logic [1:0]            o_grant,
   output logic                  o_timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             ptr_d;

   logic             req_if;
   logic             req_d;
   logic             owner_req;
   logic             completion;
   logic             timeout_hit;
   logic             arb_req_if;
   logic             arb_req_d;
   logic             arb_pri_d;
   logic [1:0]       win;

   // Route the owner's request onto the shared port and the downstream
   // response back to the owner only; everything else is held at zero.
   // A D write takes precedence over a simultaneous D read.
   always_comb begin
      o_mm_addr     = '0;
      o_mm_data     = '0;
      o_mm_wr_width = '0;
      o_mm_wr_valid = 1'b0;
      o_mm_rd_ready = 1'b0;
      o_if_rd_valid = 1'b0;
      o_if_data     = '0;
      o_d_wr_ready  = 1'b0;
      o_d_rd_valid  = 1'b0;
      o_d_data      = '0;
      case (state)
         GNT_IF: begin
            o_mm_addr     = i_if_addr;
            o_mm_rd_ready = i_if_rd_ready;
            o_if_rd_valid = i_mm_rd_valid;
            o_if_data     = i_mm_data;
         end
         GNT_D: begin
            o_mm_addr     = i_d_addr;
            o_mm_data     = i_d_data;
            o_mm_wr_width = i_d_wr_width;
            o_mm_wr_valid = i_d_wr_valid;
            o_mm_rd_ready = i_d_rd_ready & ~i_d_wr_valid;
            o_d_wr_ready  = i_mm_wr_ready;
            o_d_rd_valid  = i_mm_rd_valid;
            o_d_data      = i_mm_data;
         end
         default: begin
         end
      endcase
   end

   // Work out whether the current grant ends this edge and which requests,
   // with which preference, take part in the next arbitration.
   always_comb begin
      req_if      = i_if_rd_ready;
      req_d       = i_d_wr_valid | i_d_rd_ready;
      completion  = (o_mm_wr_valid & i_mm_wr_ready) | (o_mm_rd_ready & i_mm_rd_valid);
      owner_req   = 1'b0;
      timeout_hit = 1'b0;
      arb_req_if  = req_if;
      arb_req_d   = req_d;
      arb_pri_d   = ptr_d;
      case (state)
         GNT_IF: begin
            owner_req   = req_if;
            timeout_hit = owner_req & ~completion & (cnt == CNT_LAST);
            arb_pri_d   = 1'b1;
            if (timeout_hit) begin
               arb_req_if = 1'b0;
            end
         end
         GNT_D: begin
            owner_req   = req_d;
            timeout_hit = owner_req & ~completion & (cnt == CNT_LAST);
            if (timeout_hit) begin
               arb_pri_d = 1'b0;
               arb_req_d = 1'b0;
            end else begin
`ifdef MEM_ARB_RR_EN
               arb_pri_d = 1'b0;
`else
               arb_pri_d = 1'b1;
`endif
            end
         end
         default: begin
         end
      endcase
   end

   arb_select u_arb_select (
      .req_if (arb_req_if),
      .req_d  (arb_req_d),
      .pri_d  (arb_pri_d),
      .win    (win)
   );

   // Grant FSM with timeout counter, priority pointer and registered
   // grant/timeout outputs; completion and timeout re-arbitrate in place.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr_d     <= 1'b1;
         o_grant   <= GRANT_NONE;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         if (state == IDLE) begin
            state   <= state_for_grant(win);
            o_grant <= win;
            cnt     <= '0;
         end else if (completion || timeout_hit) begin
            state     <= state_for_grant(win);
            o_grant   <= win;
            cnt       <= '0;
            o_timeout <= timeout_hit;
`ifdef MEM_ARB_RR_EN
            ptr_d     <= (state == GNT_IF);
`endif
         end else if (!owner_req) begin
            state   <= IDLE;
            o_grant <= GRANT_NONE;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifAddr;
   logic        ifRdReady;
   logic [31:0] dAddr;
   logic [31:0] dData;
   logic [2:0]  dWrWidth;
   logic        dWrValid;
   logic        dRdReady;
   logic        mmWrReady;
   logic        mmRdValid;
   logic [31:0] mmData;

   logic        ifRdValid;
   logic [31:0] ifData;
   logic        dWrReady;
   logic        dRdValid;
   logic [31:0] dOutData;
   logic [31:0] mmAddr;
   logic [31:0] mmOutData;
   logic [2:0]  mmWrWidth;
   logic        mmWrValid;
   logic        mmRdReady;
   logic [1:0]  grant;
   logic        timeoutPulse;

   int passCount = 0;
   int failCount = 0;
   int checkCount = 0;

   // Model: who owns the port (0 none, 1 IF, 2 D), cycles held so far,
   // current preference for D, and whether a timeout pulse is due.
   int mOwner = 0;
   int mHeld = 0;
   bit mPtrD = 1'b1;
   bit mTimeout = 1'b0;

   int tCycle;
   int grantAtTimeout;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_if_addr     (ifAddr),
      .i_if_rd_ready (ifRdReady),
      .o_if_rd_valid (ifRdValid),
      .o_if_data     (ifData),
      .i_d_addr      (dAddr),
      .i_d_data      (dData),
      .i_d_wr_width  (dWrWidth),
      .i_d_wr_valid  (dWrValid),
      .o_d_wr_ready  (dWrReady),
      .i_d_rd_ready  (dRdReady),
      .o_d_rd_valid  (dRdValid),
      .o_d_data      (dOutData),
      .o_mm_addr     (mmAddr),
      .o_mm_data     (mmOutData),
      .o_mm_wr_width (mmWrWidth),
      .o_mm_wr_valid (mmWrValid),
      .i_mm_wr_ready (mmWrReady),
      .o_mm_rd_ready (mmRdReady),
      .i_mm_rd_valid (mmRdValid),
      .i_mm_data     (mmData),
      .o_grant       (grant),
      .o_timeout     (timeoutPulse)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input bit rIf, input bit rD, input bit preferD);
      if (rD && (preferD || !rIf)) return 2;
      if (rIf) return 1;
      return 0;
   endfunction

   // Advance the model by one clock edge using the inputs held before it.
   task automatic modelEdge();
      bit rIf;
      bit rD;
      bit done;
      bit own;
      bit preferD;
      int other;
      rIf = ifRdReady;
      rD = dWrValid | dRdReady;
      mTimeout = 1'b0;
      if (rst) begin
         mOwner = 0;
         mHeld = 0;
         mPtrD = 1'b1;
      end else if (mOwner == 0) begin
         mOwner = pick(rIf, rD, mPtrD);
         mHeld = 0;
      end else begin
         if (mOwner == 1) begin
            done = rIf && mmRdValid;
            own = rIf;
         end else begin
            done = dWrValid ? mmWrReady : (dRdReady && mmRdValid);
            own = rD;
         end
         if (done) begin
`ifdef MEM_ARB_RR_EN
            preferD = (mOwner == 1);
            mPtrD = preferD;
`else
            preferD = 1'b1;
`endif
            mOwner = pick(rIf, rD, preferD);
            mHeld = 0;
         end else if (!own) begin
            mOwner = 0;
         end else if (mHeld == TMO - 1) begin
            mTimeout = 1'b1;
            other = 3 - mOwner;
`ifdef MEM_ARB_RR_EN
            mPtrD = (other == 2);
`endif
            mOwner = (((other == 1) ? rIf : rD) != 1'b0) ? other : 0;
            mHeld = 0;
         end else begin
            mHeld++;
         end
      end
   endtask

   // Compare every DUT output with what the model says for the present
   // owner and the present inputs.
   task automatic checkAll();
      logic [31:0] eGrant, eAddr, eData, eWidth, eWrValid, eRdReady;
      logic [31:0] eIfValid, eIfData, eDWrReady, eDRdValid, eDData;
      eGrant = 0; eAddr = 0; eData = 0; eWidth = 0; eWrValid = 0; eRdReady = 0;
      eIfValid = 0; eIfData = 0; eDWrReady = 0; eDRdValid = 0; eDData = 0;
      if (mOwner == 1) begin
         eGrant = 1;
         eAddr = ifAddr;
         eRdReady = 32'(ifRdReady);
         eIfValid = 32'(mmRdValid);
         eIfData = mmData;
      end else if (mOwner == 2) begin
         eGrant = 2;
         eAddr = dAddr;
         eData = dData;
         eWidth = 32'(dWrWidth);
         eWrValid = 32'(dWrValid);
         eRdReady = 32'(dRdReady & ~dWrValid);
         eDWrReady = 32'(mmWrReady);
         eDRdValid = 32'(mmRdValid);
         eDData = mmData;
      end
      checkOutput("grant", 32'(grant), eGrant);
      checkOutput("timeout", 32'(timeoutPulse), 32'(mTimeout));
      checkOutput("mm_addr", mmAddr, eAddr);
      checkOutput("mm_data", mmOutData, eData);
      checkOutput("mm_wr_width", 32'(mmWrWidth), eWidth);
      checkOutput("mm_wr_valid", 32'(mmWrValid), eWrValid);
      checkOutput("mm_rd_ready", 32'(mmRdReady), eRdReady);
      checkOutput("if_rd_valid", 32'(ifRdValid), eIfValid);
      checkOutput("if_data", ifData, eIfData);
      checkOutput("d_wr_ready", 32'(dWrReady), eDWrReady);
      checkOutput("d_rd_valid", 32'(dRdValid), eDRdValid);
      checkOutput("d_data", dOutData, eDData);
   endtask

   // One cycle: settle, check, then clock the DUT and the model together.
   task automatic applyStimulus();
      #1;
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic clearInputs();
      ifAddr = 0; ifRdReady = 0; dAddr = 0; dData = 0; dWrWidth = 0;
      dWrValid = 0; dRdReady = 0; mmWrReady = 0; mmRdValid = 0; mmData = 0;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      clearInputs();
      repeat (2) begin
         @(posedge clk);
         modelEdge();
      end
      #1;
      rst = 1'b0;
   endtask

   task automatic randomizeInputs(input int respPct);
      if ($urandom_range(0, 99) < 20) ifRdReady = ~ifRdReady;
      if ($urandom_range(0, 99) < 15) dWrValid = ~dWrValid;
      if ($urandom_range(0, 99) < 15) dRdReady = ~dRdReady;
      ifAddr = $urandom;
      dAddr = $urandom;
      dData = $urandom;
      dWrWidth = 3'($urandom_range(0, 7));
      mmWrReady = ($urandom_range(0, 99) < respPct);
      mmRdValid = ($urandom_range(0, 99) < respPct);
      mmData = $urandom;
      rst = ($urandom_range(0, 199) == 0);
   endtask

   initial begin
      $display("[TB] start");

      // Reset state.
      resetDut();
      #1;
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_timeout", 32'(timeoutPulse), 32'd0);
      applyStimulus();

      // IF-only read with data returned two cycles after grant.
      ifRdReady = 1; ifAddr = 32'h10;
      applyStimulus();
      checkOutput("if_grant_latency", 32'(grant), 32'd1);
      applyStimulus();
      applyStimulus();
      mmRdValid = 1; mmData = 32'h12345678;
      #1;
      checkOutput("if_read_data", ifData, 32'h12345678);
      checkOutput("if_read_d_quiet", 32'(dRdValid) | dOutData | 32'(dWrReady), 32'd0);
      applyStimulus();
      ifRdReady = 0; mmRdValid = 0;
      applyStimulus();
      applyStimulus();

      // Simultaneous requests after reset: D first.
      resetDut();
      ifRdReady = 1; ifAddr = 32'h40; dRdReady = 1; dAddr = 32'h20;
      applyStimulus();
      checkOutput("both_first_d", 32'(grant), 32'd2);
      applyStimulus();
      mmRdValid = 1; mmData = 32'hCAFE0001;
      applyStimulus();
`ifdef MEM_ARB_RR_EN
      checkOutput("both_after_done", 32'(grant), 32'd1);
`else
      checkOutput("both_after_done", 32'(grant), 32'd2);
`endif
      dRdReady = 0; mmRdValid = 0;
      applyStimulus();
      applyStimulus();
      checkOutput("both_if_later", 32'(grant), 32'd1);
      ifRdReady = 0;
      applyStimulus();
      applyStimulus();

      // D write followed directly by a D read of the same address.
      resetDut();
      dWrValid = 1; dAddr = 32'h10; dData = 32'h11223344; dWrWidth = 3'd4;
      applyStimulus();
      checkOutput("wr_width", 32'(mmWrWidth), 32'd4);
      mmWrReady = 1;
      applyStimulus();
      dWrValid = 0; mmWrReady = 0; dRdReady = 1;
      mmRdValid = 1; mmData = 32'h11223344;
      #1;
      checkOutput("wr_rd_no_idle", 32'(grant), 32'd2);
      checkOutput("rd_after_wr_ready", 32'(mmRdReady), 32'd1);
      checkOutput("rd_after_wr_data", dOutData, 32'h11223344);
      applyStimulus();
      dRdReady = 0; mmRdValid = 0;
      applyStimulus();
      applyStimulus();

      // Downstream never responds: timeout hands the port to IF.
      resetDut();
      dRdReady = 1; dAddr = 32'h80; ifRdReady = 1; ifAddr = 32'h90;
      tCycle = -1;
      grantAtTimeout = -1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus();
         if (timeoutPulse === 1'b1 && tCycle < 0) begin
            tCycle = i;
            grantAtTimeout = int'(grant);
         end
      end
      checkOutput("timeout_cycle", 32'(tCycle), 32'd8);
      checkOutput("timeout_new_owner", 32'(grantAtTimeout), 32'd1);
      clearInputs();
      applyStimulus();
      applyStimulus();

      // Reset during a D read abandons it.
      resetDut();
      dRdReady = 1; dAddr = 32'h30;
      applyStimulus();
      applyStimulus();
      rst = 1; mmRdValid = 1;
      applyStimulus();
      checkOutput("rst_mid_grant", 32'(grant), 32'd0);
      checkOutput("rst_mid_rd_ready", 32'(mmRdReady), 32'd0);
      checkOutput("rst_mid_rd_valid", 32'(dRdValid), 32'd0);
      rst = 0; dRdReady = 0; mmRdValid = 0;
      applyStimulus();

      // D write and read together: write goes first.
      resetDut();
      dWrValid = 1; dRdReady = 1; dAddr = 32'h44; dData = 32'hA5A5A5A5; dWrWidth = 3'd2;
      applyStimulus();
      checkOutput("wr_first_valid", 32'(mmWrValid), 32'd1);
      checkOutput("wr_first_rd_hold", 32'(mmRdReady), 32'd0);
      applyStimulus();
      mmWrReady = 1;
      applyStimulus();
      dWrValid = 0; mmWrReady = 0;
      #1;
      checkOutput("rd_after_wr_done", 32'(mmRdReady), 32'd1);
      mmRdValid = 1; mmData = 32'h5A5A5A5A;
      applyStimulus();
      dRdReady = 0; mmRdValid = 0;
      applyStimulus();

      // Randomized traffic, busy then slow downstream.
      resetDut();
      for (int i = 0; i < 300; i++) begin
         randomizeInputs(35);
         applyStimulus();
      end
      for (int i = 0; i < 300; i++) begin
         randomizeInputs(4);
         applyStimulus();
      end
      rst = 0;
      clearInputs();
      applyStimulus();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
